// File: rtl/alpha_collector_pkg.sv
// rtl/alpha_collector_pkg.sv - shared FSM state type and width derivations for the alpha collector
//
// Purpose: single home for the collector state encoding and the derived widths
// (NUM_NODE_WIDTH, NUM_NODE_ADDR_W, AGGR_WIDTH) so RTL and interface agree.
// Ports: none (package).
package alpha_collector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_COLLECT = 3'd3,
    ST_SEND    = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  // Width of the per-subgraph node count field.
  function automatic int num_node_width(input int max_nodes);
    return $clog2(max_nodes);
  endfunction

  // Width of the node-count BRAM address (subgraph index).
  function automatic int num_node_addr_width(input int num_subgraphs);
    return $clog2(num_subgraphs);
  endfunction

  // Packed output word: MAX_NODES coefficient slots plus the count on top.
  function automatic int aggr_width(input int alpha_width, input int max_nodes);
    return max_nodes * alpha_width + num_node_width(max_nodes);
  endfunction

endpackage

// File: rtl/alpha_collector_if.sv
// rtl/alpha_collector_if.sv - alpha FIFO, node-count BRAM and aggregator stream bundle
//
// Purpose: groups the three external channels of the collector.
// Ports (master = collector side):
//   alpha_ff_dout / alpha_ff_empty in, alpha_ff_rd_vld out  - FWFT alpha FIFO
//   num_node_bram_addrb out, num_node_bram_dout in          - node-count BRAM, 1-cycle read
//   aggr_vld_o / aggr_data_o out, aggr_rdy_i in             - packed word to aggregator
interface alpha_collector_if #(
  parameter int ALPHA_DATA_WIDTH = 32,
  parameter int MAX_NODES        = 168,
  parameter int NUM_SUBGRAPHS    = 2708
);
  import alpha_collector_pkg::*;

  localparam int NUM_NODE_WIDTH  = num_node_width(MAX_NODES);
  localparam int NUM_NODE_ADDR_W = num_node_addr_width(NUM_SUBGRAPHS);
  localparam int AGGR_WIDTH      = aggr_width(ALPHA_DATA_WIDTH, MAX_NODES);

  logic [ALPHA_DATA_WIDTH-1:0] alpha_ff_dout;
  logic                        alpha_ff_empty;
  logic                        alpha_ff_rd_vld;
  logic [NUM_NODE_ADDR_W-1:0]  num_node_bram_addrb;
  logic [NUM_NODE_WIDTH-1:0]   num_node_bram_dout;
  logic                        aggr_vld_o;
  logic                        aggr_rdy_i;
  logic [AGGR_WIDTH-1:0]       aggr_data_o;

  modport master (
    input  alpha_ff_dout, alpha_ff_empty,
    output alpha_ff_rd_vld,
    output num_node_bram_addrb,
    input  num_node_bram_dout,
    output aggr_vld_o, aggr_data_o,
    input  aggr_rdy_i
  );

  modport slave (
    output alpha_ff_dout, alpha_ff_empty,
    input  alpha_ff_rd_vld,
    input  num_node_bram_addrb,
    output num_node_bram_dout,
    input  aggr_vld_o, aggr_data_o,
    output aggr_rdy_i
  );

endinterface

// File: rtl/alpha_pack_reg.sv
// rtl/alpha_pack_reg.sv - indexed coefficient slot register with flat packed output
//
// Purpose: holds MAX_NODES coefficient slots; one indexed write per cycle,
// synchronous clear of all slots, all slots exposed as one flat vector.
// Ports: clk, rst_n (sync active-low), clr (zero all slots), wr_en/wr_idx/wr_data
//        (slot write), flat_o (slot i at [i*ALPHA_DATA_WIDTH +: ALPHA_DATA_WIDTH]).
module alpha_pack_reg
  import alpha_collector_pkg::*;
#(
  parameter int ALPHA_DATA_WIDTH = 32,
  parameter int MAX_NODES        = 168,
  parameter int IDX_WIDTH        = num_node_width(MAX_NODES)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clr,
  input  logic                                  wr_en,
  input  logic [IDX_WIDTH-1:0]                  wr_idx,
  input  logic [ALPHA_DATA_WIDTH-1:0]           wr_data,
  output logic [MAX_NODES*ALPHA_DATA_WIDTH-1:0] flat_o
);

  logic [ALPHA_DATA_WIDTH-1:0] slot_q [MAX_NODES];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        slot_q[i] <= '0;
      end
    end else if (wr_en && (int'(wr_idx) < MAX_NODES)) begin
      slot_q[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < MAX_NODES; g++) begin : g_flat
    assign flat_o[g*ALPHA_DATA_WIDTH +: ALPHA_DATA_WIDTH] = slot_q[g];
  end

endmodule

// File: rtl/alpha_collector.sv
// rtl/alpha_collector.sv - gathers per-subgraph alpha coefficients into one packed word
//
// Purpose: on start_i, walks subgraphs 0..NUM_SUBGRAPHS-1; for each it reads the
// node count from BRAM, pops that many coefficients from the alpha FIFO into
// slots, and hands {num_node, slots} to the aggregator with a valid/ready handshake.
// Ports: clk, rst_n (sync active-low), start_i (pass start pulse),
//        done_o (one-cycle pulse after the last word is accepted),
//        bus (alpha_collector_if.master: FIFO, BRAM and aggregator channels).
module alpha_collector
  import alpha_collector_pkg::*;
#(
  parameter int ALPHA_DATA_WIDTH = 32,
  parameter int MAX_NODES        = 168,
  parameter int NUM_SUBGRAPHS    = 2708
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic               done_o,
  alpha_collector_if.master  bus
);

  localparam int NUM_NODE_WIDTH  = num_node_width(MAX_NODES);
  localparam int NUM_NODE_ADDR_W = num_node_addr_width(NUM_SUBGRAPHS);
  localparam int SLOT_BITS       = MAX_NODES * ALPHA_DATA_WIDTH;

  localparam logic [NUM_NODE_WIDTH-1:0]  MAX_COUNT = NUM_NODE_WIDTH'(MAX_NODES);
  localparam logic [NUM_NODE_ADDR_W-1:0] LAST_IDX  = NUM_NODE_ADDR_W'(NUM_SUBGRAPHS - 1);

  state_e                     state_q;
  logic [NUM_NODE_ADDR_W-1:0] idx_q;
  logic [NUM_NODE_WIDTH-1:0]  num_node_q;
  logic [NUM_NODE_WIDTH-1:0]  cnt_q;
  logic                       vld_q;
  logic                       done_q;
  logic [NUM_NODE_WIDTH-1:0]  count_clamped;
  logic                       pop;
  logic [SLOT_BITS-1:0]       slots_flat;

  // Counts beyond the slot capacity are truncated so we never pop more than fits.
  assign count_clamped = (bus.num_node_bram_dout > MAX_COUNT) ? MAX_COUNT
                                                              : bus.num_node_bram_dout;

  // FWFT FIFO: the pop must follow empty in the same cycle, so it is decoded
  // from the registered state rather than registered itself.
  assign pop = (state_q == ST_COLLECT) && !bus.alpha_ff_empty;

  alpha_pack_reg #(
    .ALPHA_DATA_WIDTH (ALPHA_DATA_WIDTH),
    .MAX_NODES        (MAX_NODES),
    .IDX_WIDTH        (NUM_NODE_WIDTH)
  ) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == ST_LOAD),
    .wr_en   (pop),
    .wr_idx  (cnt_q),
    .wr_data (bus.alpha_ff_dout),
    .flat_o  (slots_flat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      num_node_q <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_q <= ST_ADDR;
        end
        // Address is idx_q itself; this cycle lets the BRAM read complete.
        ST_ADDR: begin
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          num_node_q <= count_clamped;
          cnt_q      <= '0;
          if (count_clamped == '0) begin
            state_q <= ST_SEND;
            vld_q   <= 1'b1;
          end else begin
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (pop) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == num_node_q - 1'b1) begin
              state_q <= ST_SEND;
              vld_q   <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (bus.aggr_rdy_i) begin
            vld_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_ADDR;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done_o                  = done_q;
  assign bus.alpha_ff_rd_vld     = pop;
  assign bus.num_node_bram_addrb = idx_q;
  assign bus.aggr_vld_o          = vld_q;
  assign bus.aggr_data_o         = {num_node_q, slots_flat};

endmodule

// File: tb/tb_alpha_collector.sv
// tb/tb_alpha_collector.sv - scoreboard bench for alpha_collector
module tb_alpha_collector;
  import alpha_collector_pkg::*;

  localparam int DW   = 32;
  localparam int MAXN = 168;
  localparam int NSG  = 2;
  localparam int NNW  = $clog2(MAXN);
  localparam int AGW  = MAXN * DW + NNW;
  localparam int PASS_LIMIT = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic done_o;

  alpha_collector_if #(.ALPHA_DATA_WIDTH(DW), .MAX_NODES(MAXN), .NUM_SUBGRAPHS(NSG)) bus ();

  alpha_collector #(.ALPHA_DATA_WIDTH(DW), .MAX_NODES(MAXN), .NUM_SUBGRAPHS(NSG)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .done_o  (done_o),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int failures = 0;

  logic [AGW-1:0] exp_q[$];
  logic [DW-1:0]  fifo_q[$];
  logic [DW-1:0]  fixed_alphas[$];
  logic [NNW-1:0] bram_mem [NSG];

  int pop_cnt = 0, exp_pops = 0;
  int stall_at = 0, stall_len = 5, stall_rem = 0;
  bit rand_stall = 0, rand_rdy = 0;
  int rdy_hold = 0;
  int done_cnt = 0, cyc = 0;
  int lat_cyc = -1, t0 = 0;
  bit lat_arm = 0;
  int max_hold = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [AGW-1:0] got, input logic [AGW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      failures++;
      if (got[AGW-1 -: NNW] !== exp[AGW-1 -: NNW])
        $display("FAIL %s count got %0d expected %0d", name, got[AGW-1 -: NNW], exp[AGW-1 -: NNW]);
      else begin
        for (int i = 0; i < MAXN; i++) begin
          if (got[i*DW +: DW] !== exp[i*DW +: DW]) begin
            $display("FAIL %s slot%0d got %h expected %h", name, i, got[i*DW +: DW], exp[i*DW +: DW]);
            break;
          end
        end
      end
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // BRAM model: one-cycle read latency
  initial begin
    bus.num_node_bram_dout <= '0;
    forever begin
      @(posedge clk);
      bus.num_node_bram_dout <= bram_mem[bus.num_node_bram_addrb];
    end
  end

  // FWFT FIFO model with optional forced-empty stalls
  initial begin
    bit rs;
    bus.alpha_ff_empty <= 1'b1;
    bus.alpha_ff_dout  <= '0;
    forever begin
      @(posedge clk);
      if (bus.alpha_ff_rd_vld) begin
        chk("pop_when_nonempty", (fifo_q.size() > 0 && !bus.alpha_ff_empty), 1);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_cnt++;
        if (pop_cnt == stall_at) stall_rem = stall_len;
      end else if (stall_rem > 0) begin
        stall_rem--;
      end
      rs = rand_stall && ($urandom_range(0, 3) == 0);
      bus.alpha_ff_empty <= (fifo_q.size() == 0) || (stall_rem > 0) || rs;
      bus.alpha_ff_dout  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Ready driver
  initial begin
    bus.aggr_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_hold > 0) begin
        bus.aggr_rdy_i = 1'b0;
        if (bus.aggr_vld_o) rdy_hold--;
      end else if (rand_rdy) begin
        bus.aggr_rdy_i = 1'($urandom_range(0, 1));
      end else begin
        bus.aggr_rdy_i = 1'b1;
      end
    end
  end

  // Monitor: pops expected words on each transfer
  initial begin
    logic prev_vld;
    bit holding;
    int hold_cycles;
    logic [AGW-1:0] hold_data;
    prev_vld = 1'b0;
    holding = 0;
    hold_cycles = 0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 0;
        prev_vld = 1'b0;
      end else begin
        if (done_o) done_cnt++;
        if (bus.aggr_vld_o) begin
          chk("no_pop_while_valid", bus.alpha_ff_rd_vld, 0);
          if (!prev_vld && lat_arm) begin
            lat_cyc = cyc;
            lat_arm = 0;
          end
          if (holding) begin
            chk_word("data_stable", bus.aggr_data_o, hold_data);
            hold_cycles++;
            if (hold_cycles > max_hold) max_hold = hold_cycles;
          end else begin
            holding = 1;
            hold_data = bus.aggr_data_o;
            hold_cycles = 0;
          end
          if (bus.aggr_rdy_i) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              failures++;
              $display("FAIL unexpected_word got count %0d expected none", bus.aggr_data_o[AGW-1 -: NNW]);
            end else begin
              chk_word("word", bus.aggr_data_o, exp_q.pop_front());
            end
            holding = 0;
          end
        end
        prev_vld = bus.aggr_vld_o;
      end
    end
  end

  // Reference model: one subgraph's word from its BRAM count and next alphas
  task automatic model_subgraph(input int cnt);
    logic [AGW-1:0] w;
    logic [DW-1:0] a;
    int eff;
    eff = (cnt > MAXN) ? MAXN : cnt;
    w = '0;
    w[AGW-1 -: NNW] = NNW'(eff);
    for (int i = 0; i < eff; i++) begin
      a = (fixed_alphas.size() > 0) ? fixed_alphas.pop_front() : $urandom;
      fifo_q.push_back(a);
      w[i*DW +: DW] = a;
    end
    exp_q.push_back(w);
    exp_pops += eff;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_pass(input int c0, input int c1, input int extra, input bit dup_start);
    int k;
    int done_before;
    @(negedge clk);
    bram_mem[0] = NNW'(c0);
    bram_mem[1] = NNW'(c1);
    pop_cnt = 0;
    exp_pops = 0;
    max_hold = 0;
    model_subgraph(c0);
    model_subgraph(c1);
    for (int i = 0; i < extra; i++) fifo_q.push_back($urandom);
    done_before = done_cnt;
    t0 = cyc;
    lat_cyc = -1;
    lat_arm = 1;
    pulse_start();
    if (dup_start) begin
      repeat (3) @(negedge clk);
      pulse_start();
    end
    k = 0;
    while (done_cnt == done_before && k < PASS_LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (k >= PASS_LIMIT) begin
      n_checks++;
      failures++;
      $display("FAIL pass_timeout got %0d cycles expected done", k);
    end
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cnt - done_before, 1);
    chk("words_left", exp_q.size(), 0);
    chk("pops", pop_cnt, exp_pops);
    chk("fifo_left", fifo_q.size(), extra);
    exp_q.delete();
    fifo_q.delete();
    stall_at = 0;
  endtask

  initial begin
    int k;
    int done_before;
    bram_mem[0] = '0;
    bram_mem[1] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_vld", bus.alpha_ff_rd_vld, 0);
    chk("rst_vld", bus.aggr_vld_o, 0);
    chk("rst_data_zero", (bus.aggr_data_o == '0), 1);
    chk("rst_done", done_o, 0);
    chk("rst_addrb", bus.num_node_bram_addrb, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fixed two-subgraph pass, latency with full FIFO
    fixed_alphas.push_back(32'h4000_0000);
    fixed_alphas.push_back(32'h2000_0000);
    fixed_alphas.push_back(32'h2000_0000);
    fixed_alphas.push_back(32'h7FFF_FFFF);
    run_pass(3, 1, 0, 0);
    chk("latency", lat_cyc - t0, 3 + 3);

    // Zero-count subgraph
    run_pass(0, 2, 0, 0);
    chk("latency_zero", lat_cyc - t0, 3);

    // FIFO empty for 5 cycles after the first pop
    stall_at = 1;
    run_pass(3, 2, 1, 0);

    // Ready held low for 10 valid cycles
    rdy_hold = 10;
    run_pass(4, 3, 0, 0);
    chk("ready_hold_cycles", max_hold, 10);

    // Reset in COLLECT of subgraph 1 after 2 of 4 pops
    @(negedge clk);
    bram_mem[0] = NNW'(1);
    bram_mem[1] = NNW'(4);
    pop_cnt = 0;
    exp_pops = 0;
    model_subgraph(1);
    fifo_q.push_back($urandom);
    fifo_q.push_back($urandom);
    done_before = done_cnt;
    pulse_start();
    k = 0;
    while (pop_cnt < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reset_setup_pops", pop_cnt, 3);
    repeat (2) @(negedge clk);
    chk("reset_setup_words", exp_q.size(), 0);
    chk("reset_setup_addrb", bus.num_node_bram_addrb, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rd_vld", bus.alpha_ff_rd_vld, 0);
    chk("midrst_vld", bus.aggr_vld_o, 0);
    chk("midrst_data_zero", (bus.aggr_data_o == '0), 1);
    chk("midrst_done", done_o, 0);
    chk("midrst_addrb", bus.num_node_bram_addrb, 0);
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_done", done_cnt - done_before, 0);
    run_pass(2, 1, 0, 0);

    // Count above capacity is clamped
    run_pass(200, 1, 3, 0);

    // Randomised passes with stalls, random ready and ignored extra start
    rand_stall = 1;
    rand_rdy = 1;
    for (int p = 0; p < 6; p++) begin
      run_pass($urandom_range(0, 200), $urandom_range(0, 20), $urandom_range(0, 2), p[0]);
    end
    rand_stall = 0;
    rand_rdy = 0;
    repeat (20) @(negedge clk);
    chk("idle_no_valid", bus.aggr_vld_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alpha_collector.md
ALPHA_COLLECTOR -- requirements
Module: alpha_collector

Interface
REQ-001 SHALL have parameter ALPHA_DATA_WIDTH, default 32, width of one normalized coefficient.
REQ-002 SHALL have parameter MAX_NODES, default 168, maximum neighbours per subgraph.
REQ-003 SHALL have parameter NUM_SUBGRAPHS, default 2708, subgraphs per layer pass.
REQ-004 SHALL derive NUM_NODE_WIDTH = clog2(MAX_NODES), NUM_NODE_ADDR_W = clog2(NUM_SUBGRAPHS), AGGR_WIDTH = MAX_NODES*ALPHA_DATA_WIDTH + NUM_NODE_WIDTH.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 start_i  in  1  one-cycle pulse that begins a pass over all subgraphs.
REQ-008 alpha_ff_dout  in  ALPHA_DATA_WIDTH  head of alpha FIFO, first-word-fall-through.
REQ-009 alpha_ff_empty  in  1  alpha FIFO empty.
REQ-010 alpha_ff_rd_vld  out  1  pop strobe for alpha FIFO.
REQ-011 num_node_bram_addrb  out  NUM_NODE_ADDR_W  node-count BRAM read address.
REQ-012 num_node_bram_dout  in  NUM_NODE_WIDTH  node count, valid 1 cycle after address.
REQ-013 aggr_vld_o  out  1  packed subgraph word valid.
REQ-014 aggr_rdy_i  in  1  aggregator accepts word.
REQ-015 aggr_data_o  out  AGGR_WIDTH  packed {num_node, alpha[MAX_NODES-1..0]}.
REQ-016 done_o  out  1  one-cycle pulse after last subgraph accepted.

Function
REQ-017 SHALL implement FSM IDLE -> ADDR -> LOAD -> COLLECT -> SEND -> (ADDR | FIN) -> IDLE.
REQ-018 IDLE SHALL leave on start_i only; start_i outside IDLE SHALL be ignored.
REQ-019 ADDR SHALL drive num_node_bram_addrb = subgraph index; LOAD SHALL capture num_node_bram_dout into num_node register and clear all alpha slots to zero.
REQ-020 LOAD SHALL go to SEND directly when captured num_node = 0, else to COLLECT with slot counter = 0.
REQ-021 COLLECT SHALL assert alpha_ff_rd_vld = !alpha_ff_empty, write alpha_ff_dout into slot counter on each pop, increment counter.
REQ-022 COLLECT SHALL go to SEND in the cycle after the pop with counter = num_node-1; no extra pop SHALL occur.
REQ-023 alpha_ff_rd_vld SHALL be 0 in every state except COLLECT.
REQ-024 Slot i SHALL occupy aggr_data_o[i*ALPHA_DATA_WIDTH +: ALPHA_DATA_WIDTH]; num_node SHALL occupy top NUM_NODE_WIDTH bits; slots >= num_node SHALL be zero.
REQ-025 SEND SHALL hold aggr_vld_o=1 and aggr_data_o stable until aggr_rdy_i=1; transfer occurs on cycle with both high.
REQ-026 On transfer: index < NUM_SUBGRAPHS-1 -> increment index, go ADDR; index = NUM_SUBGRAPHS-1 -> go FIN.
REQ-027 FIN SHALL pulse done_o for exactly one cycle, reset index to 0, return to IDLE.
REQ-028 num_node > MAX_NODES SHALL be clamped to MAX_NODES.
REQ-029 FIFO empty stall mid-subgraph SHALL freeze counter and slots without loss.
REQ-030 Latency: start_i to first aggr_vld_o = 3 + num_node cycles with FIFO never empty.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, index=0, counter=0, num_node=0, slots=0.
REQ-032 During/after reset: alpha_ff_rd_vld=0, aggr_vld_o=0, aggr_data_o=0, done_o=0, num_node_bram_addrb=0.
REQ-033 Reset mid-COLLECT or mid-SEND SHALL abandon the partial word; no output pulse.

Structure
REQ-034 State enum, AGGR_WIDTH and NUM_NODE_WIDTH derivations SHALL reside in the shared GAT package.
REQ-035 Slot storage SHALL be one sub-module alpha_pack_reg (write-enable, index, clear, flat output).

Verification
REQ-036 NUM_SUBGRAPHS=2, counts {3,1}, alphas 0x40000000,0x20000000,0x20000000,0x7FFFFFFF -> two words, second: count=1, slot0=0x7FFFFFFF, rest 0; done_o once.
REQ-037 Count 0 for subgraph 0 -> word with count 0, all slots 0, zero pops.
REQ-038 Count 3, FIFO empty 5 cycles between pop 1 and 2 -> word identical to no-stall case.
REQ-039 aggr_rdy_i low 10 cycles in SEND -> aggr_data_o stable, no pops, one transfer.
REQ-040 rst_n low in COLLECT after 2 of 4 pops -> all outputs 0 next cycle; new start_i restarts at index 0.
REQ-041 Count 200 with MAX_NODES=168 -> exactly 168 pops, count field 168.
